// File: rtl/apb_slave_pkg.sv
// Shared types and sizing for the APB register slave.
package apb_slave_pkg;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;
  localparam int IDX_W     = $clog2(REG_COUNT);

  localparam logic [DATA_W-1:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;
endpackage

// File: rtl/apb_slave_regfile.sv
// 32 x 32-bit register storage; entry 0 reads as a fixed ID and is never written.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (we && idx != '0) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = (idx == '0) ? ID_VALUE : mem[idx];

endmodule

// File: rtl/apb_slave.sv
// APB slave front end: setup/access FSM, wait-state counter and error decode
// in front of a small register file.
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output state_t            dbg_state
);

  localparam int CNT_W = 3;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic              ready;
  logic              err;
  logic              we;
  logic [DATA_W-1:0] rf_rdata;

  // Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
  // access cycles (PSEL=1, PENABLE=1); it completes on the edge where
  // PREADY=1, and dropping PSEL or PENABLE during access aborts it.
  assign ready = (state_q == ST_ACCESS) && (cnt_q == '0);

  // Out-of-range, unaligned, or a write to the read-only ID entry.
  assign err = (addr_q[ADDR_W-1:IDX_W+2] != '0) ||
               (addr_q[1:0] != 2'b00) ||
               (write_q && addr_q[IDX_W+1:2] == '0);

  assign we = ready && PSEL && PENABLE && write_q && !err && !PRESET;

  assign PREADY    = ready;
  assign PSLVERR   = ready && err;
  assign PRDATA    = (ready && !write_q && !err) ? rf_rdata : '0;
  assign dbg_state = state_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
            cnt_q   <= CNT_W'(WAIT_STATES);
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!(PSEL && PENABLE)) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  apb_slave_regfile #(
    .ID_VALUE(ID_VALUE)
  ) u_regfile (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (rf_rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: three instances with different wait-state counts,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_apb_slave;
  import apb_slave_pkg::*;

  localparam int NDUT = 3;
  localparam int WS0 = 1;
  localparam int WS1 = 0;
  localparam int WS2 = 3;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  int ws [NDUT];

  logic        pclk = 1'b0;
  logic        preset  [NDUT];
  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pready  [NDUT];
  logic        pslverr [NDUT];
  state_t      dbg     [NDUT];

  int checks = 0;
  int errors = 0;

  // Reference register contents per instance, cleared on reset.
  logic [31:0] model_mem [NDUT][32];
  logic [31:0] exp_q [$];

  always #5 pclk = ~pclk;

  apb_slave #(.WAIT_STATES(WS0)) u_dut0 (
    .PCLK(pclk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .dbg_state(dbg[0]));

  apb_slave #(.WAIT_STATES(WS1)) u_dut1 (
    .PCLK(pclk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .dbg_state(dbg[1]));

  apb_slave #(.WAIT_STATES(WS2)) u_dut2 (
    .PCLK(pclk), .PRESET(preset[2]), .PSEL(psel[2]), .PENABLE(penable[2]),
    .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]),
    .PREADY(pready[2]), .PSLVERR(pslverr[2]), .dbg_state(dbg[2]));

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tab [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_all();
    @(posedge pclk); #1;
    for (int d = 0; d < NDUT; d++) begin
      preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
      pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      for (int i = 0; i < 32; i++) model_mem[d][i] = '0;
    end
    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < NDUT; d++) preset[d] = 1'b0;
    @(negedge pclk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_pready%0d", d), {31'b0, pready[d]}, 32'd0);
      chk($sformatf("rst_pslverr%0d", d), {31'b0, pslverr[d]}, 32'd0);
      chk($sformatf("rst_prdata%0d", d), prdata[d], 32'd0);
      chk($sformatf("rst_state%0d", d), 32'(dbg[d]), 32'(ST_IDLE));
    end
  endtask

  // One complete transfer; returns the completion response and how many
  // access cycles it took (PREADY cycle included).
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit scramble,
                      output logic [31:0] rd, output logic err, output int acc);
    bit done;
    @(posedge pclk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    acc = 0; rd = '0; err = 1'b0; done = 1'b0;
    while (!done) begin
      if (scramble) begin
        paddr[d]  = $urandom();
        pwdata[d] = $urandom();
      end
      @(negedge pclk);
      acc++;
      if (pready[d]) begin
        rd = prdata[d];
        err = pslverr[d];
        done = 1'b1;
      end else if (acc >= 20) begin
        checks++;
        errors++;
        $display("FAIL xfer_timeout dut%0d: got no PREADY after %0d cycles, required %0d", d, acc, ws[d] + 1);
        done = 1'b1;
      end else begin
        @(posedge pclk); #1;
      end
    end
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] rd;
    logic        err;
    int          acc;
    xfer(v.d, v.wr, v.addr, v.wdata, 1'b0, rd, err, acc);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, v.exp_err});
    chk({tag, "_lat"}, 32'(acc), 32'(ws[v.d] + 1));
  endtask

  function automatic vec_t mk(int d, bit wr, logic [31:0] a, logic [31:0] w,
                              logic [31:0] r, bit e);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = a; v.wdata = w; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, w, exp_rd;
    logic        err;
    int          acc, r;
    bit          wr, exp_err;

    ws[0] = WS0; ws[1] = WS1; ws[2] = WS2;
    for (int d = 0; d < NDUT; d++) begin
      preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
      pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    reset_all();

    // Directed vectors.
    tab.push_back(mk(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0));
    tab.push_back(mk(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0));
    tab.push_back(mk(1, 0, 32'h00, 32'h0, ID, 0));
    tab.push_back(mk(1, 1, 32'h00, 32'h1, 32'h0, 1));
    tab.push_back(mk(1, 0, 32'h00, 32'h0, ID, 0));
    tab.push_back(mk(2, 1, 32'h80, 32'h5555_5555, 32'h0, 1));
    tab.push_back(mk(2, 1, 32'h12, 32'h5555_5555, 32'h0, 1));
    tab.push_back(mk(2, 0, 32'h80, 32'h0, 32'h0, 1));
    tab.push_back(mk(2, 0, 32'h12, 32'h0, 32'h0, 1));
    for (int i = 0; i < 32; i++)
      tab.push_back(mk(2, 0, 32'(i * 4), 32'h0, (i == 0) ? ID : 32'h0, 0));
    for (int i = 0; i < tab.size(); i++) run_vec(tab[i], $sformatf("vec%0d", i));

    // Abort: drop PSEL in the second access cycle of a 3-wait write.
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h20; pwdata[2] = 32'h1234_5678;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(negedge pclk);
    chk("abort_acc1_pready", {31'b0, pready[2]}, 32'd0);
    @(posedge pclk); #1;
    psel[2] = 1'b0;
    @(negedge pclk);
    chk("abort_acc2_pready", {31'b0, pready[2]}, 32'd0);
    chk("abort_acc2_state", 32'(dbg[2]), 32'(ST_ACCESS));
    @(posedge pclk); #1;
    penable[2] = 1'b0;
    @(negedge pclk);
    chk("abort_after_pready", {31'b0, pready[2]}, 32'd0);
    chk("abort_after_state", 32'(dbg[2]), 32'(ST_IDLE));
    run_vec(mk(2, 0, 32'h20, 32'h0, 32'h0, 0), "abort_readback");

    // Reset during the access phase of a write.
    run_vec(mk(0, 1, 32'h04, 32'hA5A5_A5A5, 32'h0, 0), "rstmid_w04");
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h7C; pwdata[0] = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    preset[0] = 1'b1;
    @(posedge pclk); #1;
    preset[0] = 1'b0;
    @(negedge pclk);
    chk("rstmid_pready", {31'b0, pready[0]}, 32'd0);
    chk("rstmid_pslverr", {31'b0, pslverr[0]}, 32'd0);
    chk("rstmid_prdata", prdata[0], 32'd0);
    chk("rstmid_state", 32'(dbg[0]), 32'(ST_IDLE));
    psel[0] = 1'b0; penable[0] = 1'b0;
    run_vec(mk(0, 0, 32'h7C, 32'h0, 32'h0, 0), "rstmid_r7c");
    run_vec(mk(0, 0, 32'h04, 32'h0, 32'h0, 0), "rstmid_r04");

    // Randomized traffic against the reference register model.
    reset_all();
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 40; n++) begin
        r  = $urandom_range(0, 9);
        wr = 1'($urandom_range(0, 1));
        w  = $urandom();
        if (r < 7)       a = 32'($urandom_range(0, 31) * 4);
        else if (r == 7) a = $urandom() | 32'h0000_0100;
        else if (r == 8) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        else             a = 32'h80 + 32'($urandom_range(0, 31) * 4);

        exp_err = (a >= 32'd128) || (a % 4 != 0) || (wr && a / 4 == 0);
        if (wr || exp_err)   exp_rd = 32'h0;
        else if (a / 4 == 0) exp_rd = ID;
        else                 exp_rd = model_mem[d][a / 4];
        exp_q.push_back(exp_rd);

        xfer(d, wr, a, w, 1'b1, rd, err, acc);
        chk($sformatf("rnd%0d_%0d_rdata", d, n), rd, exp_q.pop_front());
        chk($sformatf("rnd%0d_%0d_err", d, n), {31'b0, err}, {31'b0, exp_err});
        chk($sformatf("rnd%0d_%0d_lat", d, n), 32'(acc), 32'(ws[d] + 1));
        if (wr && !exp_err) model_mem[d][a / 4] = w;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
